// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard/forwarding bus between the decoder side and hazard_scoreboard.
// Counter signals exist only when HAZARD_SCOREBOARD_STATS_EN is defined.
interface hazard_scoreboard_if #(
   parameter int unsigned REG_ADDR_W = 4,
   parameter int unsigned NUM_SRC    = 2,
   parameter int unsigned DEPTH      = 3
);
   localparam int unsigned SEL_W = $clog2(DEPTH);

   logic                          forward_EN;
   logic                          id_valid;
   logic                          flush;
   logic [NUM_SRC*REG_ADDR_W-1:0] src;
   logic [NUM_SRC-1:0]            src_used;
   logic [REG_ADDR_W-1:0]         dest;
   logic                          wb_en;
   logic                          mem_r_en;
   logic                          stall;
   logic [NUM_SRC*SEL_W-1:0]      fwd_sel;
   logic                          exe_valid;
`ifdef HAZARD_SCOREBOARD_STATS_EN
   logic [31:0]                   stall_cnt;
   logic [31:0]                   fwd_cnt;
   logic [31:0]                   flush_cnt;
`endif

   modport master (
      output forward_EN, id_valid, flush, src, src_used, dest, wb_en, mem_r_en,
`ifdef HAZARD_SCOREBOARD_STATS_EN
      input  stall_cnt, fwd_cnt, flush_cnt,
`endif
      input  stall, fwd_sel, exe_valid
   );

   modport slave (
      input  forward_EN, id_valid, flush, src, src_used, dest, wb_en, mem_r_en,
`ifdef HAZARD_SCOREBOARD_STATS_EN
      output stall_cnt, fwd_cnt, flush_cnt,
`endif
      output stall, fwd_sel, exe_valid
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// Parametrised in-flight write scoreboard: ID stall, registered EXE forwarding selects, bubbles.
// Optional saturating event counters under HAZARD_SCOREBOARD_STATS_EN.
module hazard_scoreboard #(
   parameter int unsigned REG_ADDR_W = 4,
   parameter int unsigned NUM_SRC    = 2,
   parameter int unsigned DEPTH      = 3,
   parameter int unsigned LOAD_READY = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   hazard_scoreboard_if.slave   bus
);
   localparam int unsigned SEL_W = $clog2(DEPTH);

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] dest;
      logic                  wb_en;
      logic                  is_load;
   } entry_t;

   entry_t                   ent [DEPTH];
   logic [NUM_SRC*SEL_W-1:0] cand_sel;
   logic [NUM_SRC-1:0]       src_hit;
   logic [REG_ADDR_W-1:0]    cur_src;
   logic                     found;
   logic                     stall_c;
   logic                     issue;
   logic                     any_fwd;
   logic [NUM_SRC*SEL_W-1:0] fwd_sel_q;

   // Youngest-first search over EXE..WB-1; the WB producer is covered by the register file bypass.
   always_comb begin
      cand_sel = '0;
      src_hit  = '0;
      cur_src  = '0;
      found    = 1'b0;
      for (int unsigned j = 0; j < NUM_SRC; j++) begin
         cur_src = bus.src[j*REG_ADDR_W +: REG_ADDR_W];
         found   = 1'b0;
         for (int unsigned k = 0; k < DEPTH - 1; k++) begin
            if (!found && bus.src_used[j] && ent[k].valid && ent[k].wb_en &&
                ent[k].dest == cur_src && cur_src != '0) begin
               found = 1'b1;
               if (bus.forward_EN) begin
                  cand_sel[j*SEL_W +: SEL_W] = SEL_W'(k + 1);
                  if (ent[k].is_load && (k + 1) < LOAD_READY)
                     src_hit[j] = 1'b1;
               end else begin
                  src_hit[j] = 1'b1;
               end
            end
         end
      end
   end

   assign stall_c       = (|src_hit) & bus.id_valid & ~bus.flush;
   assign issue         = bus.id_valid & ~stall_c & ~bus.flush;
   assign any_fwd       = |cand_sel;
   assign bus.stall     = stall_c;
   assign bus.fwd_sel   = fwd_sel_q;
   assign bus.exe_valid = ent[0].valid;

   // Pipeline shift; downstream never stalls, so every edge advances.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned k = 0; k < DEPTH; k++)
            ent[k] <= '0;
         fwd_sel_q <= '0;
      end else begin
         for (int unsigned k = 1; k < DEPTH; k++)
            ent[k] <= ent[k-1];
         if (issue)
            ent[0] <= '{valid: 1'b1, dest: bus.dest, wb_en: bus.wb_en, is_load: bus.mem_r_en};
         else
            ent[0] <= '0;
         fwd_sel_q <= issue ? cand_sel : '0;
      end
   end

`ifdef HAZARD_SCOREBOARD_STATS_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] fwd_cnt_q;
   logic [31:0] flush_cnt_q;

   // Saturating event counters; observation only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= '0;
         fwd_cnt_q   <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall_c && stall_cnt_q != '1)
            stall_cnt_q <= stall_cnt_q + 32'd1;
         if (issue && any_fwd && fwd_cnt_q != '1)
            fwd_cnt_q <= fwd_cnt_q + 32'd1;
         if (bus.flush && bus.id_valid && flush_cnt_q != '1)
            flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end

   assign bus.stall_cnt = stall_cnt_q;
   assign bus.fwd_cnt   = fwd_cnt_q;
   assign bus.flush_cnt = flush_cnt_q;
`else
   logic unused_any_fwd;
   assign unused_any_fwd = any_fwd;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with default parameters (REG_ADDR_W=4, NUM_SRC=2, DEPTH=3).
// Counter reset checks are compiled in when HAZARD_SCOREBOARD_STATS_EN is defined.
module tb_hazard_scoreboard;
   logic clk;
   logic rst;
   int   tests;
   int   fails;

   hazard_scoreboard_if #(.REG_ADDR_W(4), .NUM_SRC(2), .DEPTH(3)) bus ();

   hazard_scoreboard #(.REG_ADDR_W(4), .NUM_SRC(2), .DEPTH(3), .LOAD_READY(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive the ID-stage instruction; src_used bit0 = src0, bit1 = src1.
   task automatic drive(input logic v, input logic fl, input logic [3:0] s0, input logic [3:0] s1,
                        input logic [1:0] used, input logic [3:0] d, input logic wb, input logic ld);
      bus.id_valid = v;
      bus.flush    = fl;
      bus.src      = {s1, s0};
      bus.src_used = used;
      bus.dest     = d;
      bus.wb_en    = wb;
      bus.mem_r_en = ld;
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0);
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst   = 1'b0;
      bus.forward_EN = 1'b1;
      idle();
      #12;
      chk("reset_stall", 32'(bus.stall), 32'd0);
      chk("reset_fwd_sel", 32'(bus.fwd_sel), 32'd0);
      chk("reset_exe_valid", 32'(bus.exe_valid), 32'd0);
      rst = 1'b1;
      step();

      // ALU back-to-back
      drive(1'b1, 1'b0, 4'd0, 4'd0, 2'b00, 4'd3, 1'b1, 1'b0);
      chk("alu_prod_stall", 32'(bus.stall), 32'd0);
      step();
      chk("alu_prod_exe_valid", 32'(bus.exe_valid), 32'd1);
      drive(1'b1, 1'b0, 4'd3, 4'd0, 2'b01, 4'd0, 1'b0, 1'b0);
      chk("alu_cons_stall", 32'(bus.stall), 32'd0);
      step();
      chk("alu_cons_fwd_sel", 32'(bus.fwd_sel), 32'h1);
      chk("alu_cons_exe_valid", 32'(bus.exe_valid), 32'd1);
      idle(); step(); step(); step();

      // Load-use: one bubble, then forward from stage 2
      drive(1'b1, 1'b0, 4'd0, 4'd0, 2'b00, 4'd5, 1'b1, 1'b1);
      step();
      drive(1'b1, 1'b0, 4'd0, 4'd5, 2'b10, 4'd0, 1'b0, 1'b0);
      chk("lu_stall_1", 32'(bus.stall), 32'd1);
      step();
      chk("lu_bubble_exe_valid", 32'(bus.exe_valid), 32'd0);
      chk("lu_bubble_fwd_sel", 32'(bus.fwd_sel), 32'd0);
      chk("lu_stall_release", 32'(bus.stall), 32'd0);
      step();
      chk("lu_cons_fwd_sel", 32'(bus.fwd_sel), 32'h8);
      chk("lu_cons_exe_valid", 32'(bus.exe_valid), 32'd1);
      idle(); step(); step(); step();

      // Forwarding disabled: two stall cycles
      bus.forward_EN = 1'b0;
      drive(1'b1, 1'b0, 4'd0, 4'd0, 2'b00, 4'd4, 1'b1, 1'b0);
      step();
      drive(1'b1, 1'b0, 4'd4, 4'd0, 2'b01, 4'd0, 1'b0, 1'b0);
      chk("nofwd_stall_1", 32'(bus.stall), 32'd1);
      step();
      chk("nofwd_stall_2", 32'(bus.stall), 32'd1);
      chk("nofwd_bubble", 32'(bus.exe_valid), 32'd0);
      step();
      chk("nofwd_stall_release", 32'(bus.stall), 32'd0);
      step();
      chk("nofwd_fwd_sel", 32'(bus.fwd_sel), 32'd0);
      chk("nofwd_exe_valid", 32'(bus.exe_valid), 32'd1);
      idle(); step(); step(); step();
      bus.forward_EN = 1'b1;

      // Register 0 and unused sources
      drive(1'b1, 1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b1, 1'b0);
      step();
      drive(1'b1, 1'b0, 4'd0, 4'd0, 2'b01, 4'd0, 1'b0, 1'b0);
      chk("r0_stall", 32'(bus.stall), 32'd0);
      step();
      chk("r0_fwd_sel", 32'(bus.fwd_sel), 32'd0);
      drive(1'b1, 1'b0, 4'd0, 4'd0, 2'b00, 4'd6, 1'b1, 1'b1);
      step();
      drive(1'b1, 1'b0, 4'd1, 4'd6, 2'b01, 4'd0, 1'b0, 1'b0);
      chk("unused_stall", 32'(bus.stall), 32'd0);
      step();
      chk("unused_fwd_sel", 32'(bus.fwd_sel), 32'd0);
      idle(); step(); step(); step();

      // Flush beats a load-use hazard; youngest producer wins afterwards
      drive(1'b1, 1'b0, 4'd0, 4'd0, 2'b00, 4'd7, 1'b1, 1'b1);
      step();
      drive(1'b1, 1'b1, 4'd7, 4'd0, 2'b01, 4'd0, 1'b0, 1'b0);
      chk("flush_stall", 32'(bus.stall), 32'd0);
      step();
      chk("flush_bubble", 32'(bus.exe_valid), 32'd0);
      drive(1'b1, 1'b0, 4'd0, 4'd0, 2'b00, 4'd7, 1'b1, 1'b0);
      chk("flush_alu_stall", 32'(bus.stall), 32'd0);
      step();
      drive(1'b1, 1'b0, 4'd7, 4'd0, 2'b01, 4'd0, 1'b0, 1'b0);
      chk("flush_cons_stall", 32'(bus.stall), 32'd0);
      step();
      chk("flush_cons_fwd_sel", 32'(bus.fwd_sel), 32'h1);
      chk("flush_cons_exe_valid", 32'(bus.exe_valid), 32'd1);
      idle(); step(); step(); step();

      // Reset mid-flight with three writers of r2
      drive(1'b1, 1'b0, 4'd0, 4'd0, 2'b00, 4'd2, 1'b1, 1'b0);
      step();
      drive(1'b1, 1'b0, 4'd2, 4'd0, 2'b01, 4'd2, 1'b1, 1'b0);
      step();
      step();
      chk("pre_rst_fwd_sel", 32'(bus.fwd_sel), 32'h1);
      chk("pre_rst_exe_valid", 32'(bus.exe_valid), 32'd1);
      idle();
      rst = 1'b0;
      #1;
      chk("rst_exe_valid", 32'(bus.exe_valid), 32'd0);
      chk("rst_fwd_sel", 32'(bus.fwd_sel), 32'd0);
`ifdef HAZARD_SCOREBOARD_STATS_EN
      chk("rst_stall_cnt", bus.stall_cnt, 32'd0);
      chk("rst_fwd_cnt", bus.fwd_cnt, 32'd0);
      chk("rst_flush_cnt", bus.flush_cnt, 32'd0);
`endif
      step();
      rst = 1'b1;
      step();
      drive(1'b1, 1'b0, 4'd2, 4'd0, 2'b01, 4'd0, 1'b0, 1'b0);
      chk("post_rst_stall", 32'(bus.stall), 32'd0);
      step();
      chk("post_rst_fwd_sel", 32'(bus.fwd_sel), 32'd0);
      chk("post_rst_exe_valid", 32'(bus.exe_valid), 32'd1);
      idle(); step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
